// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared FSM state encoding and index-width helper for mp_add_seq
package mp_add_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction
endpackage

// File: rtl/mp_add_slice.sv
// mp_add_slice: combinational N-bit adder slice; MSB carry-in port exists only with MP_ADD_SEQ_OVF_EN
module mp_add_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
`ifdef MP_ADD_SEQ_OVF_EN
    ,
    output logic         cmsb
`endif
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
`ifdef MP_ADD_SEQ_OVF_EN
    // the sum bit is a^b^carry_in, so the carry into the MSB falls out of it
    assign cmsb = a[N-1] ^ b[N-1] ^ s[N-1];
`endif
endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: word-serial multi-precision adder, LS word first; MP_ADD_SEQ_OVF_EN adds signed overflow output ovf
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [N*WORDS-1:0]   op_a,
    input  logic [N*WORDS-1:0]   op_b,
    input  logic                 cin,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [N*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 busy
`ifdef MP_ADD_SEQ_OVF_EN
    ,
    output logic                 ovf
`endif
);
    localparam int W  = N * WORDS;
    localparam int IW = idx_width(WORDS);

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_reg, b_reg;
    logic [N-1:0]  wa, wb, ws;
    logic          wc;
    logic          last;

    assign wa          = a_reg[int'(idx)*N +: N];
    assign wb          = b_reg[int'(idx)*N +: N];
    assign last        = (idx == IW'(WORDS - 1));
    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);

`ifdef MP_ADD_SEQ_OVF_EN
    logic wcmsb;
    mp_add_slice #(.N(N)) u_slice (.a(wa), .b(wb), .cin(carry), .s(ws), .cout(wc), .cmsb(wcmsb));
`else
    mp_add_slice #(.N(N)) u_slice (.a(wa), .b(wb), .cin(carry), .s(ws), .cout(wc));
`endif

    // sequencer: latch operands, step the slice across words, hold result until consumed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef MP_ADD_SEQ_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start_valid) begin
                    a_reg <= op_a;
                    b_reg <= op_b;
                    carry <= cin;
                    idx   <= '0;
                    sum   <= '0;
`ifdef MP_ADD_SEQ_OVF_EN
                    ovf   <= 1'b0;
`endif
                    state <= RUN;
                end
                RUN: begin
                    sum[int'(idx)*N +: N] <= ws;
                    carry <= wc;
                    if (last) begin
                        cout  <= wc;
`ifdef MP_ADD_SEQ_OVF_EN
                        ovf   <= wcmsb ^ wc;
`endif
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: if (res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
Multi-precision add sequencer. It computes a W = N*WORDS bit sum by stepping one N-bit adder slice across WORDS cycles, least-significant word first, and registering the carry between words. Operand intake and result delivery use valid/ready handshakes. The block lets a narrow adder slice serve wide datapath operands without widening the slice.

Parameters:
N, 4, slice width in bits (>=1)
WORDS, 4, number of N-bit words per operand (>=1); W = N*WORDS

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
start_valid  in  1  operand request valid
start_ready  out  1  block can accept operands
op_a  in  W  operand A
op_b  in  W  operand B
cin  in  1  carry into word 0
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
sum  out  W  result
cout  out  1  carry out of the top word
busy  out  1  high in RUN or DONE

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at an edge):
  - state=IDLE, word index=0, carry reg=0.
  - Operand regs, sum=0, cout=0, res_valid=0, busy=0.
  - start_ready=1 in the first cycle after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid && start_ready: latch op_a, op_b, carry<=cin, idx<=0, clear sum reg; go to RUN.
- RUN:
  - Slice adds a_reg[idx*N +: N] + b_reg[idx*N +: N] + carry.
  - Result is written to sum[idx*N +: N]; carry<=slice cout.
  - If idx==WORDS-1: cout<=slice cout and go to DONE. Otherwise idx<=idx+1.
- DONE:
  - res_valid=1; sum and cout are held stable.
  - On res_ready: go to IDLE and drop res_valid the next cycle.
- Latency: handshake in cycle c0, then RUN in c1..c(WORDS), then res_valid=1 in cycle c0+WORDS+1.
- Throughput: start_ready is high only in IDLE, so back-to-back requests start no sooner than WORDS+2 cycles apart. There is no acceptance in the same cycle as result consumption.
- Handshakes:
  - start_valid/op_a/op_b/cin are don't-care outside an IDLE handshake.
  - Input changes during RUN/DONE are ignored.
  - res_ready outside DONE is ignored.
  - start_valid held in DONE is not accepted until IDLE.
- Arithmetic: unsigned modulo 2^W. cout is the true carry of op_a+op_b+cin.
- sum bits are undefined-free: unwritten words read 0 until RUN writes them. sum is only meaningful when res_valid=1.
- WORDS=1: a single RUN cycle, latency 2.
- Index register width is max(1, $clog2(WORDS)).
- Reset mid-RUN or mid-DONE aborts the operation. All outputs return to reset values at the next edge, and the in-flight result is lost.

Optional Feature:
Macro MP_ADD_SEQ_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit).
  - Two's-complement signed overflow of the W-bit add: carry into the MSB XOR carry out of the MSB, computed on the top word.
  - ovf is registered with cout and valid with res_valid.
  - Reset value 0; cleared on handshake accept.
- Undefined: no ovf port, no extra logic.

Decomposition:
- Shared package mp_add_pkg holds:
  - FSM state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Localparam function for index width.
- One sub-module: mp_add_slice, a combinational N-bit adder.
  - Inputs a, b, cin; outputs s, cout.
  - Also exports the MSB carry-in for the overflow feature.
- mp_add_seq instantiates it once.

Test Plan (N=4, WORDS=4, W=16 unless stated):
1. op_a=0xFFFF, op_b=0x0001, cin=0 accepted in c0 -> res_valid=1 in c5, sum=0x0000, cout=1; start_ready=0 in c1..c5.
2. op_a=0x1234, op_b=0x4321, cin=1 -> sum=0x5556, cout=0; busy=1 for exactly 5 cycles with res_ready=1.
3. Backpressure: op_a=0x00FF, op_b=0x0F01, cin=0, res_ready held 0 for 3 cycles -> sum=0x1000, cout=0 stable while res_valid=1; start_valid ignored; IDLE one cycle after res_ready=1.
4. Reset mid-op: rst_n=0 in c2 of a RUN -> after that edge sum=0, cout=0, res_valid=0, busy=0, start_ready=1; a new request completes correctly.
5. With MP_ADD_SEQ_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0; 0x8000+0xFFFF -> sum=0x7FFF, ovf=1, cout=1; 0x0003+0x0004 -> ovf=0.
6. WORDS=1, N=8: op_a=0xF0, op_b=0x20, cin=1 -> sum=0x11, cout=1, res_valid two cycles after accept.
